// File: rtl/cache_ctrl_lv1_il_mb.sv
// cache_ctrl_lv1_il_mb: set-associative read-only L1 I-cache controller with multi-beat line fill from lv2.
// Define LV1_IL_CWF_EN for critical-word-first fill (no RESP cycle, requested word returned after its beat).
module cache_ctrl_lv1_il_mb #(
  parameter int ADDR_WID   = 32,
  parameter int DATA_WID   = 32,
  parameter int ASSOC      = 4,
  parameter int ASSOC_WID  = 2,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_rd,
  input  logic [ADDR_WID-1:0]  addr_bus_cpu_lv1,
  output logic [DATA_WID-1:0]  data_bus_cpu_lv1,
  output logic                 data_in_bus_cpu_lv1_il,
  input  logic                 inv_all,
  output logic                 bus_lv1_lv2_req_proc_il,
  input  logic                 bus_lv1_lv2_gnt_proc,
  output logic                 lv2_rd,
  output logic [ADDR_WID-1:0]  addr_bus_lv1_lv2,
  input  logic [DATA_WID-1:0]  data_bus_lv1_lv2,
  input  logic                 data_in_bus_lv1_lv2,
  input  logic [ASSOC_WID-1:0] lru_replacement_proc,
  output logic [ASSOC_WID-1:0] blk_accessed_main,
  output logic                 lru_update
);
  localparam int BO = $clog2(DATA_WID/8);
  localparam int WO = $clog2(LINE_WORDS);
  localparam int IW = $clog2(SETS);
  localparam int TW = ADDR_WID - IW - WO - BO;
`ifdef LV1_IL_CWF_EN
  localparam logic CWF = 1'b1;
`else
  localparam logic CWF = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, REQ, FILL, RESP} state_t;
  state_t state_q, state_d;
  logic [SETS-1:0][ASSOC-1:0] valid_q;
  logic [TW-1:0]       tag_q [SETS][ASSOC];
  logic [DATA_WID-1:0] mem_q [SETS][ASSOC][LINE_WORDS];
  logic [ADDR_WID-1:0] base_q;
  logic [WO-1:0]       word_q, beat_q, fill_idx;
  logic [ASSOC_WID-1:0] way_q, blk_q, hit_way, vic;
  logic [DATA_WID-1:0] rdata_q;
  logic ack_q, lru_q, inv_pend_q, hit, invalidating, accept, hit_ok, miss, beat_last, unused_c;
  logic [IW-1:0] set_c, set_f;
  logic [TW-1:0] tag_c, tag_f;
  logic [WO-1:0] wrd_c;
  assign set_c = addr_bus_cpu_lv1[BO+WO +: IW];
  assign tag_c = addr_bus_cpu_lv1[ADDR_WID-1 -: TW];
  assign wrd_c = addr_bus_cpu_lv1[BO +: WO];
  assign unused_c = ^addr_bus_cpu_lv1[BO-1:0];
  assign set_f = base_q[BO+WO +: IW];
  assign tag_f = base_q[ADDR_WID-1 -: TW];
  assign fill_idx = (CWF ? word_q : '0) + beat_q;
  assign invalidating = inv_all | inv_pend_q;
  // ack_q guards the cycle in which the CPU still holds cpu_rd after its strobe
  assign accept = state_q == IDLE && cpu_rd && !ack_q;
  assign hit_ok = accept && hit && !invalidating;
  assign miss = accept && !(hit && !invalidating);
  assign beat_last = data_in_bus_lv1_lv2 && beat_q == WO'(LINE_WORDS-1);
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    vic = lru_replacement_proc;
    for (int w = ASSOC-1; w >= 0; w--) begin
      if (!valid_q[set_c][w]) vic = ASSOC_WID'(w);
      if (valid_q[set_c][w] && tag_q[set_c][w] == tag_c) begin
        hit = 1'b1;
        hit_way = ASSOC_WID'(w);
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = miss ? REQ : IDLE;
      REQ:     state_d = bus_lv1_lv2_gnt_proc ? FILL : REQ;
      FILL:    state_d = beat_last ? (CWF ? IDLE : RESP) : FILL;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    bus_lv1_lv2_req_proc_il = state_q == REQ || state_q == FILL;
    lv2_rd = state_q == FILL;
    addr_bus_lv1_lv2 = state_q == FILL ? base_q | (ADDR_WID'(fill_idx) << BO) : '0;
    data_bus_cpu_lv1 = rdata_q;
    data_in_bus_cpu_lv1_il = ack_q;
    lru_update = lru_q;
    blk_accessed_main = blk_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      base_q <= '0;
      word_q <= '0;
      beat_q <= '0;
      way_q <= '0;
      blk_q <= '0;
      rdata_q <= '0;
      ack_q <= 1'b0;
      lru_q <= 1'b0;
      inv_pend_q <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      lru_q <= 1'b0;
      if (hit_ok) begin
        rdata_q <= mem_q[set_c][hit_way][wrd_c];
        ack_q <= 1'b1;
        lru_q <= 1'b1;
        blk_q <= hit_way;
      end
      if (miss) begin
        base_q <= {addr_bus_cpu_lv1[ADDR_WID-1:BO+WO], (BO+WO)'(0)};
        word_q <= wrd_c;
        way_q <= vic;
        valid_q[set_c][vic] <= 1'b0;
      end
      if (state_q == REQ) beat_q <= '0;
      if (state_q == FILL && data_in_bus_lv1_lv2) begin
        beat_q <= beat_q + 1'b1;
        if (CWF && beat_q == '0 && cpu_rd) begin
          rdata_q <= data_bus_lv1_lv2;
          ack_q <= 1'b1;
        end
        if (beat_last) begin
          valid_q[set_f][way_q] <= 1'b1;
          lru_q <= CWF;
          blk_q <= CWF ? way_q : blk_q;
        end
      end
      if (state_q == RESP) begin
        rdata_q <= mem_q[set_f][way_q][word_q];
        ack_q <= cpu_rd;
        lru_q <= 1'b1;
        blk_q <= way_q;
      end
      if (state_q != IDLE && inv_all) inv_pend_q <= 1'b1;
      if (state_q == IDLE && invalidating) begin
        valid_q <= '0;
        inv_pend_q <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (miss) tag_q[set_c][vic] <= tag_c;
    if (state_q == FILL && data_in_bus_lv1_lv2) mem_q[set_f][way_q][fill_idx] <= data_bus_lv1_lv2;
  end
endmodule

// File: tb/tb_cache_ctrl_lv1_il_mb.sv
// tb_cache_ctrl_lv1_il_mb: randomized scoreboard bench with an abstract cache/lv2 reference model.
module tb_cache_ctrl_lv1_il_mb;
`ifdef LV1_IL_CWF_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic cpu_rd = 1'b0, inv_all = 1'b0, gnt = 1'b0, lv2_valid = 1'b0;
  logic [31:0] addr = '0, lv2_data = '0, data_cpu, addr_lv2;
  logic [1:0] lru_in = '0, blk;
  logic strobe, req, lv2_rd, lru_upd;
  always #5 clk = ~clk;
  cache_ctrl_lv1_il_mb dut (
    .clk(clk), .rst(rst), .cpu_rd(cpu_rd), .addr_bus_cpu_lv1(addr),
    .data_bus_cpu_lv1(data_cpu), .data_in_bus_cpu_lv1_il(strobe), .inv_all(inv_all),
    .bus_lv1_lv2_req_proc_il(req), .bus_lv1_lv2_gnt_proc(gnt), .lv2_rd(lv2_rd),
    .addr_bus_lv1_lv2(addr_lv2), .data_bus_lv1_lv2(lv2_data), .data_in_bus_lv1_lv2(lv2_valid),
    .lru_replacement_proc(lru_in), .blk_accessed_main(blk), .lru_update(lru_upd)
  );
  int errors = 0, checks = 0, beats = 0;
  logic [31:0] exp_data_q[$], exp_addr_q[$];
  logic [1:0] exp_blk_q[$];
  logic [21:0] mtag[64][4];
  bit mval[64][4];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h00A0_0000;
  endfunction
  task automatic model_clear();
    for (int s = 0; s < 64; s++)
      for (int w = 0; w < 4; w++) mval[s][w] = 1'b0;
  endtask
  task automatic push_fill(input logic [31:0] a);
    for (int k = 0; k < 4; k++)
      exp_addr_q.push_back({a[31:4], 2'((CWF ? int'(a[3:2]) : 0) + k), 2'b00});
  endtask
  task automatic do_read(input logic [31:0] a, input logic [1:0] lru, input bit inv_mid);
    int s = int'(a[9:4]);
    logic [21:0] t = a[31:10];
    int hw = -1, vic, cyc = 0, lat = 0;
    bit got = 0, sent = 0;
    for (int i = 0; i < 4; i++) if (mval[s][i] && mtag[s][i] == t) hw = i;
    exp_data_q.push_back(mem_f({a[31:2], 2'b00}));
    if (hw >= 0) exp_blk_q.push_back(2'(hw));
    else begin
      vic = int'(lru);
      for (int i = 3; i >= 0; i--) if (!mval[s][i]) vic = i;
      exp_blk_q.push_back(2'(vic));
      push_fill(a);
      mtag[s][vic] = t;
      mval[s][vic] = 1'b1;
    end
    cpu_rd = 1'b1;
    addr = a;
    lru_in = lru;
    while (cyc < 400) begin
      @(negedge clk);
      cyc++;
      inv_all = inv_mid && !sent && req;
      if (inv_all) sent = 1'b1;
      if (strobe && !got) begin
        got = 1'b1;
        lat = cyc;
        cpu_rd = 1'b0;
      end
      if (got && !req && cyc > lat + 2) break;
    end
    inv_all = 1'b0;
    cpu_rd = 1'b0;
    chk("read_done", 64'(got), 64'd1);
    if (hw >= 0) chk("hit_latency", 64'(lat), 64'd1);
    if (sent) model_clear();
  endtask
  task automatic do_inv();
    inv_all = 1'b1;
    @(negedge clk);
    inv_all = 1'b0;
    model_clear();
    @(negedge clk);
  endtask
  task automatic reset_mid(input logic [31:0] a);
    int b0 = beats, cyc = 0;
    exp_data_q.push_back(mem_f({a[31:2], 2'b00}));
    push_fill(a);
    cpu_rd = 1'b1;
    addr = a;
    while (cyc < 400 && beats < b0 + 3) begin
      @(negedge clk);
      #2;
      cyc++;
    end
    chk("rst_reach_beat2", 64'(beats >= b0 + 3), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_ctrl_zero", 64'({req, lv2_rd, strobe, lru_upd, blk}), 64'd0);
    chk("rst_data_zero", {data_cpu, addr_lv2}, 64'd0);
    cpu_rd = 1'b0;
    exp_data_q.delete();
    exp_addr_q.delete();
    exp_blk_q.delete();
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask
  initial forever begin
    @(negedge clk);
    gnt = req && $urandom_range(0, 1) == 1;
    if (lv2_rd && !rst && $urandom_range(0, 3) != 0) begin
      if (exp_addr_q.size() == 0) chk("lv2_addr_unexpected", 64'(addr_lv2), 64'hFFFF_FFFF_FFFF);
      else chk("lv2_addr", 64'(addr_lv2), 64'(exp_addr_q.pop_front()));
      lv2_valid = 1'b1;
      lv2_data = mem_f(addr_lv2);
      beats++;
    end else begin
      lv2_valid = 1'b0;
      lv2_data = $urandom;
    end
  end
  always @(negedge clk) if (!rst) begin
    if (strobe) begin
      if (exp_data_q.size() == 0) chk("cpu_data_unexpected", 64'(data_cpu), 64'hFFFF_FFFF_FFFF);
      else chk("cpu_data", 64'(data_cpu), 64'(exp_data_q.pop_front()));
    end
    if (lru_upd) begin
      if (exp_blk_q.size() == 0) chk("blk_unexpected", 64'(blk), 64'hFFFF);
      else chk("blk_accessed", 64'(blk), 64'(exp_blk_q.pop_front()));
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end
  initial begin
    model_clear();
    repeat (3) @(negedge clk);
    chk("reset_ctrl", 64'({req, lv2_rd, strobe, lru_upd, blk}), 64'd0);
    chk("reset_data", {data_cpu, addr_lv2}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    do_read(32'h0000_1008, 2'd0, 1'b0);
    do_read(32'h0000_100C, 2'd0, 1'b0);
    do_inv();
    for (int t = 1; t <= 5; t++) do_read({22'(t), 6'd0, 4'h4}, 2'd2, 1'b0);
    do_read({22'd3, 6'd0, 4'h8}, 2'd2, 1'b0);
    do_read(32'h0000_2010, 2'd1, 1'b1);
    do_read(32'h0000_2014, 2'd1, 1'b0);
    reset_mid(32'h0000_3020);
    do_read(32'h0000_3020, 2'd0, 1'b0);
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 19) == 0) do_inv();
      else do_read({22'($urandom_range(1, 6)), 6'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'b00},
                   2'($urandom_range(0, 3)), $urandom_range(0, 24) == 0);
    end
    repeat (5) @(negedge clk);
    chk("queues_empty", 64'(exp_data_q.size() + exp_addr_q.size() + exp_blk_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
